// File: rtl/arbiter_types.sv
// Shared types for the I/D cache-to-memory arbiter.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

    // Lines are 32 bytes; the low address bits select a byte within a line.
    localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one memory line port between the I-cache and
// the D-cache. One transaction in flight; the response is steered to its owner.
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    // Clears the byte-offset bits so memory always sees a line-aligned address.
    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-LINE_OFFSET_W){1'b1}}, {LINE_OFFSET_W{1'b0}}};

    arb_state_t        state_reg, state_next;
    arb_owner_t        last_grant_reg;
    arb_owner_t        grant_next;
    logic              take_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [LINE_W-1:0] wdata_reg;
    logic              write_reg;
    logic [LINE_W-1:0] i_rdata_reg, d_rdata_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and grant decision; conflicts go to the side not served last.
    always_comb begin
        state_next = state_reg;
        grant_next = last_grant_reg;
        take_next  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (i_read && (d_read || d_write)) begin
                    grant_next = (last_grant_reg == OWNER_I) ? OWNER_D : OWNER_I;
                    take_next  = 1'b1;
                end else if (i_read) begin
                    grant_next = OWNER_I;
                    take_next  = 1'b1;
                end else if (d_read || d_write) begin
                    grant_next = OWNER_D;
                    take_next  = 1'b1;
                end
                if (take_next) begin
                    state_next = (grant_next == OWNER_D) ? D_BUSY : I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the granted request so memory sees stable values while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= OWNER_I;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            write_reg      <= 1'b0;
        end else if (take_next) begin
            last_grant_reg <= grant_next;
            write_reg      <= (grant_next == OWNER_D) && d_write;
            if (grant_next == OWNER_D) begin
                addr_reg  <= d_addr & LINE_MASK;
                wdata_reg <= d_wdata;
            end else begin
                addr_reg  <= i_addr & LINE_MASK;
            end
        end
    end

    // Keep the last returned line for each side so rdata holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            if (i_resp) begin
                i_rdata_reg <= pmem_rdata;
            end
            if (d_resp) begin
                d_rdata_reg <= pmem_rdata;
            end
        end
    end

    // Memory strobes follow the busy state; responses pass through in the completion cycle.
    always_comb begin
        pmem_read  = (state_reg != IDLE) && !write_reg;
        pmem_write = (state_reg != IDLE) &&  write_reg;
        pmem_addr  = addr_reg;
        pmem_wdata = wdata_reg;
        i_resp     = (state_reg == I_BUSY) && pmem_resp;
        d_resp     = (state_reg == D_BUSY) && pmem_resp;
        i_rdata    = i_resp ? pmem_rdata : i_rdata_reg;
        d_rdata    = d_resp ? pmem_rdata : d_rdata_reg;
    end

endmodule
